// File: rtl/dbus_pkg.sv
// Shared constants for the data-bus responder: MMIO page base, register offsets
// and STATUS bit layout, plus the offset decoder used by the top level.
package dbus_pkg;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

  localparam logic [7:0] OFS_LED     = 8'h00;
  localparam logic [7:0] OFS_CNT_LO  = 8'h04;
  localparam logic [7:0] OFS_CNT_HI  = 8'h08;
  localparam logic [7:0] OFS_TX_DATA = 8'h10;
  localparam logic [7:0] OFS_STATUS  = 8'h14;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_LED,
    REG_CNT_LO,
    REG_CNT_HI,
    REG_TX_DATA,
    REG_STATUS
  } mmio_reg_e;

  // Offsets are word aligned, so only the word index within the page matters.
  function automatic mmio_reg_e decode_offset(input logic [5:0] word_ofs);
    mmio_reg_e sel;
    sel = REG_NONE;
    case (word_ofs)
      OFS_LED[7:2]:     sel = REG_LED;
      OFS_CNT_LO[7:2]:  sel = REG_CNT_LO;
      OFS_CNT_HI[7:2]:  sel = REG_CNT_HI;
      OFS_TX_DATA[7:2]: sel = REG_TX_DATA;
      OFS_STATUS[7:2]:  sel = REG_STATUS;
      default:          sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/data_bus_responder_tx_fifo.sv
// Byte-wide first-word-fall-through transmit FIFO. Owns storage, pointers,
// occupancy and the push-accept rule (a full FIFO accepts a push only alongside a pop).
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          push_rejected
);

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop_ok, push_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign count = count_q;
  assign head  = empty ? 8'h00 : mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    pop_ok        = pop && !empty;
    push_ok       = push && (!full || pop_ok);
    push_rejected = push && !push_ok;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; stale entries are never visible
  // because head is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/data_bus_responder.sv
// Data-memory responder: decodes core accesses into a word RAM or the MMIO page
// (LED, 64-bit cycle counter, TX FIFO status/data). Reads are combinational and side-effect free.
module data_bus_responder
  import dbus_pkg::*;
#(
  parameter int RAM_AW   = 10,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic        mem_write,
  output logic [31:0] data_out,
  output logic [15:0] led_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [31:0]       ram_q [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_sel, mmio_sel;
  mmio_reg_e         reg_sel;

  logic              ram_we, led_we, cnt_clr, tx_push, stat_wr;
  logic [15:0]       led_q, led_d;
  logic [63:0]       cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic [7:0]        fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty, fifo_rejected, fifo_pop;
  logic [31:0]       status_word;

  // Byte lane bits are meaningless for a word-only bus.
  logic              unused_lane_bits;
  assign unused_lane_bits = ^addr_in[1:0];

  always_comb begin
    ram_sel  = (addr_in[31:RAM_AW+2] == '0);
    mmio_sel = (addr_in[31:8] == MMIO_BASE[31:8]);
    ram_idx  = addr_in[RAM_AW+1:2];
    reg_sel  = mmio_sel ? decode_offset(addr_in[7:2]) : REG_NONE;

    ram_we   = mem_write && ram_sel;
    led_we   = mem_write && (reg_sel == REG_LED);
    cnt_clr  = mem_write && (reg_sel == REG_CNT_LO);
    tx_push  = mem_write && (reg_sel == REG_TX_DATA);
    stat_wr  = mem_write && (reg_sel == REG_STATUS);
  end

  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_head;
  assign fifo_pop = tx_valid && tx_ready;
  assign led_out  = led_q;

  tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk           (clk),
    .rst           (rst),
    .push          (tx_push),
    .push_data     (data_in[7:0]),
    .pop           (fifo_pop),
    .head          (fifo_head),
    .count         (fifo_count),
    .full          (fifo_full),
    .empty         (fifo_empty),
    .push_rejected (fifo_rejected)
  );

  always_comb begin
    led_d = led_we ? data_in[15:0] : led_q;
    // A CNT_LO write wins over the increment so the next read sees zero.
    cnt_d = cnt_clr ? 64'd0 : cnt_q + 64'd1;
    ovf_d = ovf_q;
    if (stat_wr && data_in[STAT_OVF_BIT]) ovf_d = 1'b0;
    // A dropped byte in the same cycle as a clear leaves the flag set.
    if (fifo_rejected) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      led_q <= led_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we && !rst) ram_q[ram_idx] <= data_in;
  end

  always_comb begin
    status_word                           = '0;
    status_word[STAT_COUNT_LSB +: 8]      = 8'(fifo_count);
    status_word[STAT_OVF_BIT]             = ovf_q;
    status_word[STAT_FULL_BIT]            = fifo_full;
    status_word[STAT_EMPTY_BIT]           = fifo_empty;
  end

  always_comb begin
    data_out = '0;
    if (ram_sel) begin
      data_out = ram_q[ram_idx];
    end else begin
      case (reg_sel)
        REG_LED:    data_out = {16'h0000, led_q};
        REG_CNT_LO: data_out = cnt_q[31:0];
        REG_CNT_HI: data_out = cnt_q[63:32];
        REG_STATUS: data_out = status_word;
        default:    data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: vector table for RAM/MMIO/unmapped decode, hand
// sequences for counter, FIFO fill/drain/wrap and mid-stream reset, with a byte scoreboard.
module tb_data_bus_responder;

  localparam logic [31:0] A_LED    = 32'hFFFF_0000;
  localparam logic [31:0] A_CNT_LO = 32'hFFFF_0004;
  localparam logic [31:0] A_CNT_HI = 32'hFFFF_0008;
  localparam logic [31:0] A_OTHER  = 32'hFFFF_000C;
  localparam logic [31:0] A_TX     = 32'hFFFF_0010;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0014;
  localparam int          DEPTH    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_in, data_in, data_out;
  logic        mem_write, tx_valid, tx_ready;
  logic [15:0] led_out;
  logic [7:0]  tx_data;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  sb_q[$];
  int          model_cnt = 0;
  logic        model_ovf = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        chk;
    logic [31:0] exp;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[17];

  data_bus_responder #(
    .RAM_AW   (10),
    .TX_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .mem_write (mem_write),
    .data_out  (data_out),
    .led_out   (led_out),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] status_exp();
    return {16'h0000, 8'(model_cnt), 5'b0, model_ovf, model_cnt == DEPTH, model_cnt == 0};
  endfunction

  // Combinational read with no clock edge; caller sits just after a falling edge.
  task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr_in   = a;
    mem_write = 1'b0;
    #1;
    check(name, 64'(data_out), 64'(exp));
  endtask

  // One bus cycle starting just after a falling edge; checks the read data,
  // the FIFO head against the scoreboard, then updates the FIFO model.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we,
                      input logic rdy, input logic chk, input logic [31:0] exp,
                      input string name);
    logic pop_m, is_push, push_ok;
    addr_in   = a;
    data_in   = d;
    mem_write = we;
    tx_ready  = rdy;
    #1;
    if (chk) check(name, 64'(data_out), 64'(exp));
    check("tx_valid", 64'(tx_valid), 64'(model_cnt != 0));
    if (model_cnt != 0) check("tx_head", 64'(tx_data), 64'(sb_q[0]));
    pop_m   = (model_cnt != 0) && rdy;
    is_push = we && (a == A_TX);
    push_ok = is_push && ((model_cnt < DEPTH) || pop_m);
    if (pop_m) void'(sb_q.pop_front());
    if (push_ok) sb_q.push_back(d[7:0]);
    model_cnt = model_cnt + int'(push_ok) - int'(pop_m);
    if (we && (a == A_STATUS) && d[2]) model_ovf = 1'b0;
    if (is_push && !push_ok) model_ovf = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         16'h0000};
    vecs[1]  = '{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 16'h0000};
    vecs[2]  = '{32'h0000_0013, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 16'h0000};
    vecs[3]  = '{32'h0000_0014, 32'h0000_0001, 1'b1, 1'b0, 32'h0,         16'h0000};
    vecs[4]  = '{32'h0000_0014, 32'h0,         1'b0, 1'b1, 32'h0000_0001, 16'h0000};
    vecs[5]  = '{A_LED,         32'h0001_A5A5, 1'b1, 1'b0, 32'h0,         16'hA5A5};
    vecs[6]  = '{A_LED,         32'h0,         1'b0, 1'b1, 32'h0000_A5A5, 16'hA5A5};
    vecs[7]  = '{32'h8000_0000, 32'h1234_5678, 1'b1, 1'b0, 32'h0,         16'hA5A5};
    vecs[8]  = '{32'h8000_0000, 32'h0,         1'b0, 1'b1, 32'h0,         16'hA5A5};
    vecs[9]  = '{A_LED,         32'h0,         1'b0, 1'b1, 32'h0000_A5A5, 16'hA5A5};
    vecs[10] = '{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 16'hA5A5};
    vecs[11] = '{A_TX,          32'h0,         1'b0, 1'b1, 32'h0,         16'hA5A5};
    vecs[12] = '{A_OTHER,       32'h0,         1'b0, 1'b1, 32'h0,         16'hA5A5};
    vecs[13] = '{A_CNT_HI,      32'h0,         1'b0, 1'b1, 32'h0000_0001, 16'hA5A5};
    vecs[14] = '{A_CNT_HI,      32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,         16'hA5A5};
    vecs[15] = '{A_CNT_HI,      32'h0,         1'b0, 1'b1, 32'h0000_0001, 16'hA5A5};
    vecs[16] = '{32'h0001_0000, 32'h0,         1'b0, 1'b1, 32'h0,         16'hA5A5};

    rst       = 1'b1;
    addr_in   = '0;
    data_in   = '0;
    mem_write = 1'b0;
    tx_ready  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_led", 64'(led_out), 64'h0);
    check("rst_tx_valid", 64'(tx_valid), 64'h0);
    check("rst_tx_data", 64'(tx_data), 64'h0);
    peek(A_STATUS, 32'h0000_0001, "rst_status");
    peek(A_CNT_LO, 32'h0, "rst_cnt_lo");

    // Counter: 100 rising edges after release
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    step(A_CNT_LO, 32'h0, 1'b0, 1'b0, 1'b1, 32'd100, "cnt_100");
    step(A_CNT_LO, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, "cnt_clr");
    step(A_CNT_LO, 32'h0, 1'b0, 1'b0, 1'b1, 32'd0, "cnt_after_clr");
    step(A_CNT_LO, 32'h0, 1'b0, 1'b0, 1'b1, 32'd1, "cnt_after_clr_plus1");

    // Counter carry into the high word
    force dut.cnt_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.cnt_q;
    @(posedge clk);
    @(negedge clk);
    peek(A_CNT_HI, 32'h0000_0001, "cnt_carry_hi");
    peek(A_CNT_LO, 32'h0000_0000, "cnt_carry_lo");

    // Decode table: RAM, LED, unmapped, other offsets
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].addr, vecs[i].wdata, vecs[i].we, 1'b0, vecs[i].chk, vecs[i].exp,
           $sformatf("vec%0d", i));
      check($sformatf("vec%0d_led", i), 64'(led_out), 64'(vecs[i].exp_led));
    end

    // FIFO fill with the consumer stalled, then overflow
    for (int i = 0; i < DEPTH; i++) step(A_TX, 32'h41 + 32'(i), 1'b1, 1'b0, 1'b0, 32'h0, "push");
    step(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0802, "status_full");
    step(A_TX, 32'h49, 1'b1, 1'b0, 1'b0, 32'h0, "push_overflow");
    step(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0806, "status_ovf");
    step(A_STATUS, 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, "ovf_clear");
    step(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0802, "status_ovf_cleared");

    // Drain one per cycle, in order
    for (int i = 0; i < DEPTH; i++) step(A_OTHER, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, "drain");
    step(A_STATUS, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0001, "status_drained");

    // Refill across the pointer wrap, then push+pop while full
    for (int i = 0; i < DEPTH; i++) step(A_TX, 32'h51 + 32'(i), 1'b1, 1'b0, 1'b0, 32'h0, "refill");
    step(A_TX, 32'h59, 1'b1, 1'b1, 1'b0, 32'h0, "push_pop_full");
    step(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, status_exp(), "status_push_pop");
    check("model_push_pop_cnt", 64'(model_cnt), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) step(A_OTHER, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, "drain2");
    step(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0001, "status_drained2");

    // Reset mid-stream
    for (int i = 0; i < 3; i++) step(A_TX, 32'h61 + 32'(i), 1'b1, 1'b0, 1'b0, 32'h0, "push_pre_rst");
    step(A_LED, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, 32'h0, "led_pre_rst");
    step(32'h0000_0020, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h0, "ram_pre_rst");
    mem_write = 1'b0;
    check("led_before_rst", 64'(led_out), 64'h00FF);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_led", 64'(led_out), 64'h0);
    check("async_rst_tx_valid", 64'(tx_valid), 64'h0);
    check("async_rst_tx_data", 64'(tx_data), 64'h0);
    addr_in   = A_LED;
    data_in   = 32'h0000_1234;
    mem_write = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_write = 1'b0;
    check("rst_write_lost", 64'(led_out), 64'h0);
    rst = 1'b0;
    sb_q.delete();
    model_cnt = 0;
    model_ovf = 1'b0;
    step(A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0001, "status_after_rst");
    step(32'h0000_0020, 32'h0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, "ram_survives_rst");
    step(A_LED, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, "led_read_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
